// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin frame arbiter in front of one uart_tx.
// Holds one requester for a whole frame and sequences start/busy.
module uart_tx_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ACK_TIMEOUT = 16,
  localparam int GW = $clog2(NUM_CH),
  localparam int CW = $clog2(ACK_TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_data,
  input  logic [NUM_CH-1:0]     req_last,
  output logic [NUM_CH-1:0]     req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [GW-1:0]         grant_id,
  output logic                  active,
  output logic                  timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic          active_q, active_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic          any_req;
  logic [GW-1:0] win;
  logic          g_valid;
  logic          g_last;
  logic [7:0]    g_data;
  logic          byte_done;
  logic [GW-1:0] rr_next;

  // (a + k) mod NUM_CH, safe for non-power-of-two channel counts
  function automatic logic [GW-1:0] add_mod(
    input logic [GW-1:0] a,
    input int            k
  );
    logic [GW:0] s;
    s = {1'b0, a} + (GW+1)'(k);
    if (s >= (GW+1)'(NUM_CH)) begin
      s = s - (GW+1)'(NUM_CH);
    end
    return s[GW-1:0];
  endfunction

  assign rr_next = add_mod(grant_q, 1);

  // First valid requester searching upward from rr_q with wrap
  always_comb begin
    logic [GW-1:0] cand;
    any_req = 1'b0;
    win     = rr_q;
    cand    = rr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = add_mod(rr_q, k);
      for (int j = 0; j < NUM_CH; j++) begin
        if (!any_req && cand == GW'(j)
            && req_valid[j]) begin
          any_req = 1'b1;
          win     = cand;
        end
      end
    end
  end

  // Select byte, valid and last of the locked channel
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q == GW'(k)) begin
        g_valid = req_valid[k];
        g_last  = req_last[k];
        g_data  = req_data[8*k +: 8];
      end
    end
  end

  // Ready only toward the locked channel while fetching
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      req_ready[k] = (state_q == S_FETCH)
                   && (grant_q == GW'(k))
                   && req_valid[k];
    end
  end

  // Frame sequencing: grant, fetch, start handshake, wait
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    active_d  = active_q;
    data_d    = data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    terr_d    = 1'b0;
    byte_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d  = win;
          active_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (g_valid) begin
          data_d  = g_data;
          last_d  = g_last;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          state_d = S_WAIT;
        end else if (cnt_q == CW'(ACK_TIMEOUT-1)) begin
          terr_d    = 1'b1;
          byte_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (byte_done) begin
      if (last_q) begin
        rr_d     = rr_next;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end else begin
        state_d = S_FETCH;
      end
    end
    start_d = (state_d == S_START);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      active_q <= 1'b0;
      data_q   <= '0;
      start_q  <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      active_q <= active_d;
      data_q   <= data_d;
      start_q  <= start_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign tx_data     = data_q;
  assign tx_start    = start_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter.
// Requester queues, a busy model and a round-robin frame model.
module tb_uart_tx_arbiter;

  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   req_valid = '0;
  logic [8*NCH-1:0] req_data = '0;
  logic [NCH-1:0]   req_last = '0;
  logic [NCH-1:0]   req_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy = 1'b0;
  logic [1:0]       grant_id;
  logic             active;
  logic             timeout_err;

  uart_tx_arbiter #(
    .NUM_CH(NCH),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;

  logic [8:0] mem [NCH][256];
  int  rd [NCH] = '{default: 0};
  int  wr [NCH] = '{default: 0};
  bit  hs [NCH] = '{default: 0};
  int  gap [NCH] = '{default: 0};
  bit  in_frame [NCH] = '{default: 0};
  bit  gap_en = 1'b0;
  bit  bfm_en = 1'b1;
  bit  rand_en = 1'b0;
  int  busy_left = 0;
  int  ack_dly = 0;

  int         cap_ch [$];
  logic [7:0] cap_data [$];
  int         cap_len [$];
  bit         prev_start = 1'b0;
  int         cur_len = 0;

  int         exp_c [$];
  logic [7:0] exp_d [$];

  int         nfr [NCH];
  int         flen [NCH][4];
  logic [7:0] fb [NCH][4][4];
  int         nf [NCH];
  int         mp = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic push(input int c, input logic [7:0] d,
                      input bit last);
    mem[c][wr[c][7:0]] = {last, d};
    wr[c]++;
  endtask

  task automatic ex(input int c, input logic [7:0] d);
    exp_c.push_back(c);
    exp_d.push_back(d);
  endtask

  function automatic bit drained();
    bit ok;
    ok = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (rd[c] != wr[c]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_idle(input int max);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
      done = !active && !tx_busy && drained();
    end
    chk("idle_reached", done, 1);
  endtask

  task automatic cmp_stream(input int base);
    chk("stream_len", cap_data.size() - base, exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (base + i < cap_data.size()) begin
        chk($sformatf("stream_ch[%0d]", i),
            cap_ch[base+i], exp_c[i]);
        chk($sformatf("stream_data[%0d]", i),
            cap_data[base+i], exp_d[i]);
      end
    end
    exp_c.delete();
    exp_d.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_tx_start"}, tx_start, 0);
    chk({pfx, "_tx_data"}, tx_data, 0);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_grant"}, grant_id, 0);
    chk({pfx, "_active"}, active, 0);
    chk({pfx, "_timeout"}, timeout_err, 0);
  endtask

  // Requesters: present queued bytes, advance on handshake
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (hs[c]) begin
        in_frame[c] = !mem[c][rd[c][7:0]][8];
        rd[c]++;
        if (gap_en && in_frame[c]
            && $urandom_range(0, 3) == 0) begin
          gap[c] = $urandom_range(1, 5);
        end
      end else if (gap[c] > 0) begin
        gap[c]--;
      end
      req_valid[c] = (rd[c] < wr[c]) && (gap[c] == 0);
      req_data[8*c +: 8] = mem[c][rd[c][7:0]][7:0];
      req_last[c] = mem[c][rd[c][7:0]][8];
    end
  end

  // Transmitter model: answers tx_start with a busy window
  always @(posedge clk) begin
    #1;
    if (!bfm_en) begin
      tx_busy = 1'b0;
      busy_left = 0;
    end else if (tx_busy) begin
      busy_left--;
      if (busy_left <= 0) begin
        tx_busy = 1'b0;
        ack_dly = rand_en ? $urandom_range(0, 3) : 0;
      end
    end else if (tx_start) begin
      if (rand_en && ack_dly > 0) begin
        ack_dly--;
      end else begin
        tx_busy = 1'b1;
        busy_left = rand_en ? $urandom_range(1, 6) : 10;
      end
    end
  end

  // Monitor: handshakes, ready exclusivity, start windows
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      hs[c] = req_valid[c] && req_ready[c] && !reset;
    end
    vectors++;
    assert ($countones(req_ready) <= 1) else begin
      errors++;
      $error("FAIL ready_onehot: observed %b expected at most one bit",
             req_ready);
    end
    if (tx_start) begin
      if (!prev_start) begin
        cap_ch.push_back(int'(grant_id));
        cap_data.push_back(tx_data);
        cur_len = 0;
      end
      cur_len++;
    end else if (prev_start) begin
      cap_len.push_back(cur_len);
    end
    prev_start = tx_start;
  end

  initial begin
    int base;
    int n;
    int bad;
    int lenv;
    int found;
    int c;
    logic [7:0] b;

    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < 256; j++) mem[i][j] = '0;
    end

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // single two-byte frame on ch0
    base = cap_data.size();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    @(negedge clk);
    chk("t1_ready_idle", req_ready, 0);
    chk("t1_active_idle", active, 0);
    @(negedge clk);
    chk("t1_ready_fetch", req_ready, 4'b0001);
    chk("t1_active", active, 1);
    chk("t1_grant", grant_id, 0);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_data0", tx_data, 8'h41);
    n = 0;
    while (tx_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t1_busy_fell", tx_busy, 0);
    chk("t1_gap_start", tx_start, 0);
    chk("t1_gap_active", active, 1);
    @(negedge clk);
    chk("t1_ready_b1", req_ready, 4'b0001);
    @(negedge clk);
    chk("t1_start_b1", tx_start, 1);
    chk("t1_data1", tx_data, 8'h42);
    wait_idle(100);
    ex(0, 8'h41);
    ex(0, 8'h42);
    cmp_stream(base);
    chk("t1_grant_end", grant_id, 0);
    chk("t1_active_end", active, 0);

    // round robin between ch1 and ch2
    do_reset();
    base = cap_data.size();
    push(1, 8'hA1, 1'b1);
    push(1, 8'hA3, 1'b1);
    push(2, 8'hB2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_first_grant", grant_id, 1);
    wait_idle(200);
    ex(1, 8'hA1);
    ex(2, 8'hB2);
    ex(1, 8'hA3);
    cmp_stream(base);

    // frame lock while ch0 stalls mid-frame
    do_reset();
    base = cap_data.size();
    push(0, 8'h10, 1'b0);
    push(3, 8'h33, 1'b1);
    n = 0;
    while (cap_data.size() <= base && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_first_byte", cap_data.size(), base + 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready[3] || grant_id != 2'd0 || !active) bad++;
    end
    chk("t3_lock", bad, 0);
    push(0, 8'h11, 1'b1);
    wait_idle(200);
    ex(0, 8'h10);
    ex(0, 8'h11);
    ex(3, 8'h33);
    cmp_stream(base);

    // ack timeout with busy stuck low
    bfm_en = 1'b0;
    base = cap_data.size();
    push(2, 8'h55, 1'b1);
    n = 0;
    while (!tx_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_start_seen", tx_start, 1);
    chk("t4_data", tx_data, 8'h55);
    n = 0;
    while (tx_start && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4_start_hold", n, 16);
    chk("t4_terr", timeout_err, 1);
    chk("t4_active", active, 0);
    @(negedge clk);
    chk("t4_terr_pulse", timeout_err, 0);
    chk("t4_grant", grant_id, 2);
    bfm_en = 1'b1;
    ex(2, 8'h55);
    cmp_stream(base);

    // pointer wrap after ch3
    base = cap_data.size();
    push(3, 8'h3A, 1'b1);
    wait_idle(100);
    push(0, 8'h0A, 1'b1);
    push(3, 8'h3B, 1'b1);
    wait_idle(200);
    ex(3, 8'h3A);
    ex(0, 8'h0A);
    ex(3, 8'h3B);
    cmp_stream(base);

    // randomized frames against round-robin frame model
    do_reset();
    rand_en = 1'b1;
    gap_en = 1'b1;
    mp = 0;
    for (int r = 0; r < 4; r++) begin
      base = cap_data.size();
      for (int ch = 0; ch < NCH; ch++) begin
        nfr[ch] = $urandom_range(0, 3);
        nf[ch] = 0;
        for (int f = 0; f < nfr[ch]; f++) begin
          flen[ch][f] = $urandom_range(1, 4);
          for (int k = 0; k < flen[ch][f]; k++) begin
            b = 8'($urandom);
            fb[ch][f][k] = b;
            push(ch, b, k == flen[ch][f] - 1);
          end
        end
      end
      for (int s = 0; s < NCH * 4; s++) begin
        found = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (mp + k) % NCH;
          if (found < 0 && nf[c] < nfr[c]) found = c;
        end
        if (found >= 0) begin
          for (int k = 0; k < flen[found][nf[found]]; k++) begin
            ex(found, fb[found][nf[found]][k]);
          end
          nf[found]++;
          mp = (found + 1) % NCH;
        end
      end
      wait_idle(3000);
      cmp_stream(base);
    end
    rand_en = 1'b0;
    gap_en = 1'b0;

    // reset during WAIT of a three-byte frame
    base = cap_data.size();
    push(1, 8'h01, 1'b0);
    push(1, 8'h02, 1'b0);
    push(1, 8'h03, 1'b1);
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t7_busy_seen", tx_busy, 1);
    @(negedge clk);
    push(0, 8'hC0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("t7");
    reset = 1'b0;
    @(negedge clk);
    chk("t7_fresh_grant", grant_id, 0);
    chk("t7_fresh_active", active, 1);
    wait_idle(300);
    chk("t7_len_count", cap_len.size(), base + 4);
    lenv = (cap_len.size() > base + 1) ? cap_len[base+1] : -1;
    chk("t7_start_busy_high", lenv, 1);
    ex(1, 8'h01);
    ex(0, 8'hC0);
    ex(1, 8'h02);
    ex(1, 8'h03);
    cmp_stream(base);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
